wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage and a long-latency execution unit (MUL/DIV, 64-bit).
- Sits between the writeback cycle's result mux and the register file write inputs.
- Pipeline writes pass through with zero added latency and always win the port.
- Long-latency results are buffered and drained into free write slots. A stall request is raised if a buffered result starves.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_pend_buf.sv | 89 ++++++++
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
//   XLEN         : datapath width of buffered long-latency results
//   REG_ADDR_W   : register-file address width
//   arb_state_e  : starvation tracking states
//   pend_entry_t : one pending-buffer slot {valid, rd, data}
package wb_arb_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        STARVE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } pend_entry_t;

endpackage

// File: rtl/wb_pend_buf.sv
// Circular pending buffer for long-latency results.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   push/push_rd/data   : store a new valid entry at the tail
//   pop                 : retire the head slot (drained or hole)
//   kill/kill_rd        : clear valid on every slot whose rd matches kill_rd
//   head_busy           : buffer holds at least one slot (valid or hole)
//   head_vld            : head slot exists and is still valid
//   head_rd/head_data   : head slot contents
//   next_vld            : slot behind the head exists and is valid
//   full                : occupancy == DEPTH
module wb_pend_buf
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output logic                  head_busy,
    output logic                  head_vld,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic                  next_vld,
    output logic                  full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    pend_entry_t         mem_q [DEPTH];
    pend_entry_t         mem_d [DEPTH];
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PtrW-1:0]     nxt_ptr;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            // Pipeline write is younger: any buffered result to the same rd is stale.
            if (kill && (mem_q[i].rd == kill_rd)) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop) begin
            mem_d[head_q].valid = 1'b0;
        end
        if (push) begin
            mem_d[tail_q] = '{valid: 1'b1, rd: push_rd, data: push_data};
        end
        // DEPTH is a power of two, so pointers wrap naturally.
        head_d = head_q + PtrW'(pop);
        tail_d = tail_q + PtrW'(push);
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign nxt_ptr   = head_q + PtrW'(1);
    assign head_busy = (cnt_q != '0);
    assign head_vld  = head_busy && mem_q[head_q].valid;
    assign head_rd   = mem_q[head_q].rd;
    assign head_data = mem_q[head_q].data;
    assign next_vld  = (cnt_q > CntW'(1)) && mem_q[nxt_ptr].valid;
    assign full      = (cnt_q == CntW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the writeback stage and a
// long-latency unit. Pipeline writes pass through combinationally and always
// win; long-latency results are buffered and drained into idle write slots.
// A starving head entry raises stall_req toward the hazard unit.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   RegWriteW/RdW/ResultW     : pipeline writeback request
//   lu_valid/lu_rd/lu_data    : long-latency result, accepted when lu_ready
//   lu_ready                  : buffer not full (registered state only)
//   RegWrite_out/Rd_out/WD_out: register-file write port
//   stall_req                 : registered front-end freeze request
// Optional build macro WB_ARB_PERF_EN adds perf_conflicts and
// perf_stall_cycles (32-bit wrapping event counters).
// XLEN must match wb_arb_pkg::XLEN, which sizes the buffer entries.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = wb_arb_pkg::XLEN,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteW,
    input  logic [wb_arb_pkg::REG_ADDR_W-1:0] RdW,
    input  logic [XLEN-1:0]                   ResultW,
    input  logic                              lu_valid,
    input  logic [wb_arb_pkg::REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]                   lu_data,
    output logic                              lu_ready,
    output logic                              RegWrite_out,
    output logic [wb_arb_pkg::REG_ADDR_W-1:0] Rd_out,
    output logic [XLEN-1:0]                   WD_out,
    output logic                              stall_req
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                       perf_conflicts,
    output logic [31:0]                       perf_stall_cycles
`endif
);

    import wb_arb_pkg::*;

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic                  pipe_wr;
    logic                  push;
    logic                  pop;
    logic                  drain;
    logic                  head_kill;
    logic                  head_busy;
    logic                  head_vld;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  next_vld;
    logic                  full;

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  stall_q, stall_d;

    assign pipe_wr   = RegWriteW && (RdW != '0);
    // x0 results and results already overwritten by this cycle's pipeline
    // write complete the handshake but are not stored.
    assign push      = lu_valid && lu_ready && (lu_rd != '0) && !(pipe_wr && (lu_rd == RdW));
    assign drain     = head_vld && !pipe_wr;
    // Holes (killed heads) retire in one cycle without using the port.
    assign pop       = drain || (head_busy && !head_vld);
    assign head_kill = pipe_wr && head_vld && (head_rd == RdW);
    assign lu_ready  = !full;

    wb_pend_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (pop),
        .kill      (pipe_wr),
        .kill_rd   (RdW),
        .head_busy (head_busy),
        .head_vld  (head_vld),
        .head_rd   (head_rd),
        .head_data (head_data),
        .next_vld  (next_vld),
        .full      (full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Next state and starvation counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (drain || head_kill || !head_vld) begin
            cnt_d = '0;
        end else if (cnt_q != Limit) begin
            cnt_d = cnt_q + CntW'(1);
        end

        case (state_q)
            IDLE: begin
                if (head_vld && !drain && !head_kill) begin
                    state_d = (cnt_d == Limit) ? STARVE : PEND;
                end
            end
            PEND, STARVE: begin
                if (drain) begin
                    state_d = next_vld ? PEND : IDLE;
                end else if (head_kill || !head_vld) begin
                    state_d = IDLE;
                end else if (cnt_d == Limit) begin
                    state_d = STARVE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == STARVE);
    end

    // Outputs: write-port mux and stall request.
    always_comb begin
        RegWrite_out = 1'b0;
        Rd_out       = '0;
        WD_out       = '0;
        if (!rst) begin
            RegWrite_out = 1'b0;
        end else if (pipe_wr) begin
            RegWrite_out = 1'b1;
            Rd_out       = RdW;
            WD_out       = ResultW;
        end else if (drain) begin
            RegWrite_out = 1'b1;
            Rd_out       = head_rd;
            WD_out       = head_data;
        end
        stall_req = stall_q;
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflicts    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_conflicts    <= perf_conflicts + 32'(pipe_wr && head_vld);
            perf_stall_cycles <= perf_stall_cycles + 32'(stall_q);
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [63:0] ResultW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [63:0] lu_data;
    logic        lu_ready;
    logic        RegWrite_out;
    logic [4:0]  Rd_out;
    logic [63:0] WD_out;
    logic        stall_req;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conflicts;
    logic [31:0] perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN         (64),
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .RegWrite_out (RegWrite_out),
        .Rd_out       (Rd_out),
        .WD_out       (WD_out),
        .stall_req    (stall_req)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflicts    (perf_conflicts),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [63:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        RegWriteW = rw;
        RdW       = rd;
        ResultW   = res;
        lu_valid  = lv;
        lu_rd     = lrd;
        lu_data   = ld;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: write port forced off even with a live pipeline request.
        rst = 1'b0;
        drive(1'b1, 5'd3, 64'h5, 1'b0, 5'd0, 64'h0);
        #2;
        chk("rst_we", RegWrite_out, 1'b0);
        chk("rst_ready", lu_ready, 1'b1);
        chk("rst_stall", stall_req, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        cyc();

        // Single LU result drains the cycle after acceptance.
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'hAA);
        #1;
        chk("t1_ready", lu_ready, 1'b1);
        chk("t1_no_same_cycle", RegWrite_out, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t1_we", RegWrite_out, 1'b1);
        chk("t1_rd", Rd_out, 64'd5);
        chk("t1_wd", WD_out, 64'hAA);
        cyc();
        #1;
        chk("t1_empty", RegWrite_out, 1'b0);
        cyc();

        // Pipeline owns the port while four LU results fill the buffer.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 64'h300 + 64'(i), 1'b1, 5'd7, 64'h700 + 64'(i));
            #1;
            chk($sformatf("t2_pipe_rd%0d", i), Rd_out, 64'd3);
            chk($sformatf("t2_pipe_wd%0d", i), WD_out, 64'h300 + 64'(i));
            chk($sformatf("t2_ready%0d", i), lu_ready, 1'b1);
            cyc();
        end
        drive(1'b1, 5'd3, 64'h304, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t2_full", lu_ready, 1'b0);
        chk("t2_pipe_wins", WD_out, 64'h304);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
            #1;
            chk($sformatf("t2_drain_we%0d", i), RegWrite_out, 1'b1);
            chk($sformatf("t2_drain_rd%0d", i), Rd_out, 64'd7);
            chk($sformatf("t2_drain_wd%0d", i), WD_out, 64'h700 + 64'(i));
            chk($sformatf("t2_drain_ready%0d", i), lu_ready, (i == 0) ? 1'b0 : 1'b1);
            cyc();
        end
        #1;
        chk("t2_done_we", RegWrite_out, 1'b0);

        // Starvation: one pending entry blocked by continuous pipeline writes.
        drive(1'b1, 5'd3, 64'h31, 1'b1, 5'd12, 64'hC0FFEE);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 5'd3, 64'h31, 1'b0, 5'd0, 64'h0);
            #1;
            chk($sformatf("t3_no_stall%0d", k), stall_req, 1'b0);
            cyc();
        end
        drive(1'b1, 5'd3, 64'h31, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t3_stall_c9", stall_req, 1'b1);
        chk("t3_pipe_c9", Rd_out, 64'd3);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t3_stall_drain", stall_req, 1'b1);
        chk("t3_drain_we", RegWrite_out, 1'b1);
        chk("t3_drain_rd", Rd_out, 64'd12);
        chk("t3_drain_wd", WD_out, 64'hC0FFEE);
        cyc();
        #1;
        chk("t3_stall_clr", stall_req, 1'b0);
        chk("t3_idle_we", RegWrite_out, 1'b0);
        cyc();

        // WAW kill: pending rd=9 overwritten by pipeline, hole pops, rd=10 follows.
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h99);
        cyc();
        drive(1'b1, 5'd9, 64'h1, 1'b1, 5'd10, 64'hA0);
        #1;
        chk("t4_pipe_rd", Rd_out, 64'd9);
        chk("t4_pipe_wd", WD_out, 64'h1);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t4_hole_we", RegWrite_out, 1'b0);
        cyc();
        #1;
        chk("t4_next_we", RegWrite_out, 1'b1);
        chk("t4_next_rd", Rd_out, 64'd10);
        chk("t4_next_wd", WD_out, 64'hA0);
        cyc();
        #1;
        chk("t4_empty_we", RegWrite_out, 1'b0);
        cyc();

        // Same-cycle LU arrival to the pipeline's rd is accepted and dropped.
        drive(1'b1, 5'd11, 64'h1111, 1'b1, 5'd11, 64'hBB);
        #1;
        chk("t4b_pipe_wd", WD_out, 64'h1111);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t4b_dropped", RegWrite_out, 1'b0);
        cyc();

        // x0 on both sources: nothing written, nothing stored.
        drive(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'hDEAD);
        #1;
        chk("t5_we", RegWrite_out, 1'b0);
        chk("t5_rd", Rd_out, 64'd0);
        chk("t5_wd", WD_out, 64'd0);
        chk("t5_ready", lu_ready, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t5_after_we", RegWrite_out, 1'b0);
        cyc();

        // Three entries pending (x0 result above must not occupy a slot),
        // then reset asserted mid-drain.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 64'h22, 1'b1, 5'd20 + 5'(i), 64'h2000 + 64'(i));
            cyc();
        end
        drive(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t6_ready_3", lu_ready, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("t6_drain_rd", Rd_out, 64'd20);
        chk("t6_drain_wd", WD_out, 64'h2000);
        rst = 1'b0;
        #1;
        chk("t6_rst_we", RegWrite_out, 1'b0);
        chk("t6_rst_ready", lu_ready, 1'b1);
        cyc();
        cyc();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("t6_post_we%0d", j), RegWrite_out, 1'b0);
            chk($sformatf("t6_post_ready%0d", j), lu_ready, 1'b1);
            chk($sformatf("t6_post_stall%0d", j), stall_req, 1'b0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
